// File: rtl/control_multiciclo.sv
// Main control FSM for the multicycle MIPS datapath. Moore outputs are
// registered from the next state, so they always match the current state.
module control_multiciclo (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [1:0] ULAop,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    REXEC    = 4'd6,
    RWB      = 4'd7,
    BEQ      = 4'd8,
    JUMP     = 4'd9,
    ADDIEXEC = 4'd10,
    ADDIWB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       ulasrca;
    logic [1:0] ulasrcb;
    logic [1:0] ulaop;
    logic [1:0] pcsource;
  } ctl_t;

  state_t st, nxt;
  ctl_t   ctl;

  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memread = 1'b1; c.irwrite = 1'b1; c.ulasrcb = 2'b01; c.pcwrite = 1'b1;
      end
      DECODE:            c.ulasrcb = 2'b11;
      MEMADR, ADDIEXEC: begin
        c.ulasrca = 1'b1; c.ulasrcb = 2'b10;
      end
      MEMRD:  begin c.memread  = 1'b1; c.iord = 1'b1; end
      MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      REXEC:  begin c.ulasrca  = 1'b1; c.ulaop = 2'b10; end
      RWB:    begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      ADDIWB:        c.regwrite = 1'b1;
      BEQ: begin
        c.ulasrca = 1'b1; c.ulaop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'b01;
      end
      JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Any unreachable encoding falls back to FETCH via the default.
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:  nxt = DECODE;
      DECODE:
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = REXEC;
          OP_BEQ:       nxt = BEQ;
          OP_J:         nxt = JUMP;
          OP_ADDI:      nxt = ADDIEXEC;
          default:      nxt = FETCH;
        endcase
      MEMADR:   nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    nxt = MEMWB;
      REXEC:    nxt = RWB;
      ADDIEXEC: nxt = ADDIWB;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= FETCH;
      ctl <= state_ctl(FETCH);
    end else begin
      st  <= nxt;
      ctl <= state_ctl(nxt);
    end
  end

  always_comb begin
    illegal_op = 1'b0;
    if (st == DECODE)
      case (opcode)
        OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
        default:                                    illegal_op = 1'b1;
      endcase
  end

  assign state       = st;
  assign PCWrite     = ctl.pcwrite;
  assign PCWriteCond = ctl.pcwritecond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.memread;
  assign MemWrite    = ctl.memwrite;
  assign IRWrite     = ctl.irwrite;
  assign MemtoReg    = ctl.memtoreg;
  assign RegDst      = ctl.regdst;
  assign RegWrite    = ctl.regwrite;
  assign ULASrcA     = ctl.ulasrca;
  assign ULASrcB     = ctl.ulasrcb;
  assign ULAop       = ctl.ulaop;
  assign PCSource    = ctl.pcsource;

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: directed instruction table, random instruction
// stream against a path model, and asynchronous reset mid-instruction.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ULASrcA, illegal_op;
  logic [1:0] ULASrcB, ULAop, PCSource;
  logic [3:0] state;

  int passed = 0;
  int total  = 0;

  control_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .ULAop(ULAop),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, pcsrc;
  } ctl_t;

  typedef logic [3:0] path_t[$];

  typedef struct {
    logic [5:0]      op;
    int              len;
    logic [4:0][3:0] seq;  // seq[4] is the first state
  } vec_t;

  function automatic bit legal(logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Control values each state must present, straight from the signal list.
  function automatic ctl_t exp_ctl(logic [3:0] s);
    ctl_t c = '0;
    if (s == 0) begin c.mrd = 1; c.irw = 1; c.srcb = 2'b01; c.pcw = 1; end
    if (s == 1) c.srcb = 2'b11;
    if (s == 2 || s == 10) begin c.srca = 1; c.srcb = 2'b10; end
    if (s == 3) begin c.mrd = 1; c.iord = 1; end
    if (s == 5) begin c.mwr = 1; c.iord = 1; end
    if (s == 4) begin c.rw = 1; c.m2r = 1; end
    if (s == 6) begin c.srca = 1; c.aop = 2'b10; end
    if (s == 7) begin c.rw = 1; c.rdst = 1; end
    if (s == 11) c.rw = 1;
    if (s == 8) begin c.srca = 1; c.aop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
    if (s == 9) begin c.pcw = 1; c.pcsrc = 2'b10; end
    return c;
  endfunction

  // Instruction-level model: the list of states an opcode walks through.
  function automatic path_t model_path(logic [5:0] op);
    path_t p;
    p.push_back(4'd0);
    p.push_back(4'd1);
    case (op)
      6'b100011: begin p.push_back(4'd2); p.push_back(4'd3); p.push_back(4'd4); end
      6'b101011: begin p.push_back(4'd2); p.push_back(4'd5); end
      6'b000000: begin p.push_back(4'd6); p.push_back(4'd7); end
      6'b001000: begin p.push_back(4'd10); p.push_back(4'd11); end
      6'b000100: p.push_back(4'd8);
      6'b000010: p.push_back(4'd9);
      default: ;
    endcase
    return p;
  endfunction

  function automatic ctl_t act_ctl();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ULASrcA, ULASrcB, ULAop, PCSource};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Called at a falling edge while the FSM should be in exp_st; opcode is
  // scrambled in states that must ignore it.
  task automatic check_cycle(input logic [3:0] exp_st, input logic [5:0] op);
    opcode = (exp_st == 4'd1 || exp_st == 4'd2) ? op : 6'($urandom);
    #1;
    chk("state", 32'(state), 32'(exp_st));
    chk("ctl", 32'(act_ctl()), 32'(exp_ctl(exp_st)));
    chk("illegal_op", 32'(illegal_op), 32'(exp_st == 4'd1 && !legal(op)));
    @(negedge clk);
  endtask

  vec_t vecs[7];
  path_t p;
  logic [5:0] op;

  initial begin
    vecs[0] = '{op: 6'b100011, len: 5, seq: {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}};
    vecs[1] = '{op: 6'b101011, len: 4, seq: {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}};
    vecs[2] = '{op: 6'b000000, len: 4, seq: {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}};
    vecs[3] = '{op: 6'b000100, len: 3, seq: {4'd0, 4'd1, 4'd8, 4'd0, 4'd0}};
    vecs[4] = '{op: 6'b000010, len: 3, seq: {4'd0, 4'd1, 4'd9, 4'd0, 4'd0}};
    vecs[5] = '{op: 6'b001000, len: 4, seq: {4'd0, 4'd1, 4'd10, 4'd11, 4'd0}};
    vecs[6] = '{op: 6'b111111, len: 2, seq: {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}};

    reset = 1'b1;
    opcode = 6'b000000;
    #3;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl", 32'(act_ctl()), 32'(exp_ctl(4'd0)));
    chk("reset_illegal", 32'(illegal_op), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold_state", 32'(state), 32'd0);
    reset = 1'b0;

    // Directed table, back-to-back (beq then j included).
    for (int v = 0; v < 7; v++)
      for (int i = 0; i < vecs[v].len; i++)
        check_cycle(vecs[v].seq[4-i], vecs[v].op);

    // lw interrupted in MEMRD by asynchronous reset.
    check_cycle(4'd0, 6'b100011);
    check_cycle(4'd1, 6'b100011);
    check_cycle(4'd2, 6'b100011);
    opcode = 6'b100011;
    #1;
    chk("pre_reset_memrd", 32'(state), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_ctl", 32'(act_ctl()), 32'(exp_ctl(4'd0)));
    @(negedge clk);
    chk("held_reset_ctl", 32'(act_ctl()), 32'(exp_ctl(4'd0)));
    reset = 1'b0;
    check_cycle(4'd0, 6'b001000);
    check_cycle(4'd1, 6'b001000);
    check_cycle(4'd10, 6'b001000);
    check_cycle(4'd11, 6'b001000);

    // Random instruction stream against the path model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      p = model_path(op);
      foreach (p[i]) check_cycle(p[i], op);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Main control unit for the multicycle MIPS datapath. It is the producer of the `ULAop` code that the ALU control decoder consumes. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back, driving every datapath enable and mux select. Supported opcodes are R-type, lw, sw, beq, j and addi; all other opcodes are trapped and flagged.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; forces state to FETCH.
- `opcode` in 6: instruction bits [31:26] from the instruction register.
- `PCWrite` out 1: unconditional PC load.
- `PCWriteCond` out 1: PC load qualified by ALU zero (beq).
- `IorD` out 1: memory address select (0 = PC, 1 = ALUOut).
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: write-back data select (0 = ALUOut, 1 = MDR).
- `RegDst` out 1: destination register select (0 = rt, 1 = rd).
- `RegWrite` out 1: register file write enable.
- `ULASrcA` out 1: ALU operand A select (0 = PC, 1 = A).
- `ULASrcB` out 2: ALU operand B select (00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2).
- `ULAop` out 2: to ALU control (00 = add, 01 = sub, 10 = use funct).
- `PCSource` out 2: next-PC select (00 = ALU, 01 = ALUOut, 10 = jump target).
- `illegal_op` out 1: high during DECODE when the opcode is unsupported.
- `state` out 4: current state encoding, for debug.

## Operation
- State register is 4 bits.
- State encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, REXEC = 6, RWB = 7, BEQ = 8, JUMP = 9, ADDIEXEC = 10, ADDIWB = 11.
- Encodings 12–15 are unreachable. If reached, the next state is FETCH and all outputs are 0.
- Transitions:
  - FETCH → DECODE.
  - DECODE → by opcode:
    - 100011 (lw) or 101011 (sw): MEMADR.
    - 000000 (R-type): REXEC.
    - 000100 (beq): BEQ.
    - 000010 (j): JUMP.
    - 001000 (addi): ADDIEXEC.
    - Any other opcode: FETCH.
  - MEMADR → MEMRD if opcode is 100011, otherwise MEMWR.
  - MEMRD → MEMWB.
  - REXEC → RWB.
  - ADDIEXEC → ADDIWB.
  - MEMWB, MEMWR, RWB, BEQ, JUMP and ADDIWB → FETCH.
- Outputs are purely a function of `state` (Moore). `illegal_op` is the one exception: it also depends on `opcode` in DECODE.
- Every signal not listed for a state is 0:
  - FETCH: MemRead = 1, IRWrite = 1, IorD = 0, ULASrcA = 0, ULASrcB = 01, ULAop = 00, PCWrite = 1, PCSource = 00.
  - DECODE: ULASrcA = 0, ULASrcB = 11, ULAop = 00.
  - MEMADR and ADDIEXEC: ULASrcA = 1, ULASrcB = 10, ULAop = 00.
  - MEMRD: MemRead = 1, IorD = 1.
  - MEMWR: MemWrite = 1, IorD = 1.
  - MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0.
  - REXEC: ULASrcA = 1, ULASrcB = 00, ULAop = 10.
  - RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0.
  - ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0.
  - BEQ: ULASrcA = 1, ULASrcB = 00, ULAop = 01, PCWriteCond = 1, PCSource = 01.
  - JUMP: PCWrite = 1, PCSource = 10.
- `opcode` is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- At most one of MemRead and MemWrite is high in any cycle. RegWrite is never high together with either memory strobe.

## Timing
- The state register updates on the rising `clk` edge. Outputs settle combinationally within the same cycle.
- Reset:
  - Asserting `reset` sets `state` = 0 immediately, with no clock edge needed.
  - While reset is held, outputs equal the FETCH values and `illegal_op` = 0.
  - The first edge after deassertion moves the FSM to DECODE.
  - Reset in the middle of an instruction aborts it. No further write strobes from that instruction are issued.
- Cycles per instruction, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Back-to-back instructions need no idle cycle: FETCH follows the last state of the previous instruction directly.

## Test plan
- Reset mid-lw (in MEMRD) → on reset assertion, `state` = 0 asynchronously; MemRead = 1, IRWrite = 1, PCWrite = 1, all other strobes = 0.
- opcode = 100011 after reset → state sequence 0, 1, 2, 3, 4, 0; RegWrite = 1 and MemtoReg = 1 only in state 4.
- opcode = 101011 → sequence 0, 1, 2, 5, 0; MemWrite = 1 and IorD = 1 only in state 5; RegWrite never high.
- opcode = 000000 → ULAop = 10 in state 6, RegDst = 1 and RegWrite = 1 in state 7. Chain with an ALU control instance: funct = 101010 yields control 111 in state 6.
- opcode = 000100, then 000010 back-to-back → state 8 with ULAop = 01, PCWriteCond = 1, PCSource = 01; then 0, 1, 9 with PCWrite = 1, PCSource = 10.
- opcode = 111111 → DECODE shows `illegal_op` = 1, then FETCH. Changing opcode to 001000 in any state other than DECODE or MEMADR leaves the sequence unchanged.
